// File: rtl/hdmi_cfg_sequencer_if.sv
// Command/response channel between the ADV7511 configuration sequencer and the shared I2C master.
interface hdmi_cfg_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [6:0] cmd_dev;
    logic [7:0] cmd_reg;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_nack;

    modport master (
        output cmd_valid, cmd_dev, cmd_reg, cmd_data,
        input  cmd_ready, rsp_valid, rsp_nack
    );

    modport slave (
        input  cmd_valid, cmd_dev, cmd_reg, cmd_data,
        output cmd_ready, rsp_valid, rsp_nack
    );
endinterface

// File: rtl/hdmi_cfg_sequencer.sv
// ADV7511 bring-up: waits for hot-plug and power-up delay, writes a fixed register table over
// the I2C command channel with NACK/timeout retries, and releases the video path when done.
module hdmi_cfg_sequencer #(
    parameter logic [6:0]  DEV_ADDR      = 7'h39,
    parameter logic [23:0] POWERUP_DELAY = 24'd14_850_000,
    parameter logic [19:0] RSP_TIMEOUT   = 20'd750_000,
    parameter logic [15:0] RETRY_GAP     = 16'd7_425,
    parameter logic [1:0]  MAX_RETRIES   = 2'd3
) (
    input  logic                 clk_in,
    input  logic                 reset_n,
    input  logic                 hpd,
    hdmi_cfg_sequencer_if.master i2c,
    output logic                 video_reset,
    output logic                 config_done,
    output logic                 config_error,
    output logic [2:0]           state_dbg
);

    typedef enum logic [2:0] {
        WAIT_HPD   = 3'd0,
        POWER_WAIT = 3'd1,
        ISSUE      = 3'd2,
        WAIT_RSP   = 3'd3,
        RETRY      = 3'd4,
        DONE       = 3'd5,
        ERROR      = 3'd6
    } state_t;

    localparam logic [23:0] PWR_LAST   = POWERUP_DELAY - 24'd1;
    localparam logic [23:0] TMO_LAST   = {4'd0, RSP_TIMEOUT} - 24'd1;
    localparam logic [23:0] GAP_LAST   = {8'd0, RETRY_GAP} - 24'd1;
    localparam logic [3:0]  LAST_INDEX = 4'd12;

    function automatic logic [15:0] table_entry(input logic [3:0] idx);
        case (idx)
            4'd0:    return 16'h4110;
            4'd1:    return 16'h9803;
            4'd2:    return 16'h9AE0;
            4'd3:    return 16'h9C30;
            4'd4:    return 16'h9D61;
            4'd5:    return 16'hA2A4;
            4'd6:    return 16'hA3A4;
            4'd7:    return 16'hE0D0;
            4'd8:    return 16'hF900;
            4'd9:    return 16'h1500;
            4'd10:   return 16'h1630;
            4'd11:   return 16'h1702;
            4'd12:   return 16'hAF06;
            default: return 16'h0000;
        endcase
    endfunction

    state_t      state;
    state_t      next_state;
    logic [3:0]  index;
    logic [3:0]  next_index;
    logic [1:0]  retry;
    logic [1:0]  next_retry;
    logic [23:0] cnt;
    logic [23:0] cnt_last;
    logic        hpd_meta;
    logic        hpd_sync;
    logic        hpd_lost;
    logic        unplug;
    logic [7:0]  cmd_reg_q;
    logic [7:0]  cmd_data_q;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            hpd_meta <= 1'b0;
            hpd_sync <= 1'b0;
        end else begin
            hpd_meta <= hpd;
            hpd_sync <= hpd_meta;
        end
    end

    // An unplug seen mid-transaction is remembered so the transaction can finish first.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            hpd_lost <= 1'b0;
        end else if (state == WAIT_HPD) begin
            hpd_lost <= 1'b0;
        end else if (!hpd_sync && (state == ISSUE || state == WAIT_RSP || state == RETRY)) begin
            hpd_lost <= 1'b1;
        end
    end

    assign unplug = hpd_lost | ~hpd_sync;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state      <= WAIT_HPD;
            index      <= 4'd0;
            retry      <= 2'd0;
            cnt        <= 24'd0;
            cmd_reg_q  <= 8'h00;
            cmd_data_q <= 8'h00;
        end else begin
            state <= next_state;
            index <= next_index;
            retry <= next_retry;
            if (next_state != state) begin
                cnt <= 24'd0;
            end else if (cnt != cnt_last) begin
                cnt <= cnt + 24'd1;
            end
            if (next_state == ISSUE) begin
                {cmd_reg_q, cmd_data_q} <= table_entry(next_index);
            end
        end
    end

    always_comb begin
        next_state = state;
        next_index = index;
        next_retry = retry;
        cnt_last   = 24'd0;
        case (state)
            WAIT_HPD: begin
                if (hpd_sync) begin
                    next_state = POWER_WAIT;
                end
            end
            POWER_WAIT: begin
                cnt_last = PWR_LAST;
                if (!hpd_sync) begin
                    next_state = WAIT_HPD;
                end else if (cnt == PWR_LAST) begin
                    next_state = ISSUE;
                    next_index = 4'd0;
                    next_retry = 2'd0;
                end
            end
            ISSUE: begin
                if (i2c.cmd_ready) begin
                    next_state = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                cnt_last = TMO_LAST;
                // A response landing on the timeout cycle takes priority over the timeout.
                if (i2c.rsp_valid && !i2c.rsp_nack) begin
                    if (unplug) begin
                        next_state = WAIT_HPD;
                    end else if (index == LAST_INDEX) begin
                        next_state = DONE;
                    end else begin
                        next_state = ISSUE;
                        next_index = index + 4'd1;
                        next_retry = 2'd0;
                    end
                end else if (i2c.rsp_valid || cnt == TMO_LAST) begin
                    if (unplug) begin
                        next_state = WAIT_HPD;
                    end else if (retry < MAX_RETRIES) begin
                        next_state = RETRY;
                        next_retry = retry + 2'd1;
                    end else begin
                        next_state = ERROR;
                    end
                end
            end
            RETRY: begin
                cnt_last = GAP_LAST;
                if (unplug) begin
                    next_state = WAIT_HPD;
                end else if (cnt == GAP_LAST) begin
                    next_state = ISSUE;
                end
            end
            DONE, ERROR: begin
                if (!hpd_sync) begin
                    next_state = WAIT_HPD;
                end
            end
            default: begin
                next_state = WAIT_HPD;
            end
        endcase
    end

    assign i2c.cmd_valid = (state == ISSUE);
    assign i2c.cmd_dev   = DEV_ADDR;
    assign i2c.cmd_reg   = cmd_reg_q;
    assign i2c.cmd_data  = cmd_data_q;
    assign video_reset   = (state != DONE);
    assign config_done   = (state == DONE);
    assign config_error  = (state == ERROR);
    assign state_dbg     = state;

endmodule

// File: tb/tb_hdmi_cfg_sequencer.sv
// Directed bench for hdmi_cfg_sequencer: an I2C master model with scripted ACK/NACK/stall
// behaviour, and one task per scenario comparing against hand-computed values.
module tb_hdmi_cfg_sequencer;

    localparam logic [15:0] EXP [13] = '{
        16'h4110, 16'h9803, 16'h9AE0, 16'h9C30, 16'h9D61, 16'hA2A4, 16'hA3A4,
        16'hE0D0, 16'hF900, 16'h1500, 16'h1630, 16'h1702, 16'hAF06
    };

    logic       clk = 1'b0;
    logic       reset_n;
    logic       hpd;
    logic       video_reset;
    logic       config_done;
    logic       config_error;
    logic [2:0] state_dbg;

    always #5 clk = ~clk;

    hdmi_cfg_sequencer_if bus();

    hdmi_cfg_sequencer #(
        .DEV_ADDR      (7'h39),
        .POWERUP_DELAY (24'd16),
        .RSP_TIMEOUT   (20'd32),
        .RETRY_GAP     (16'd4),
        .MAX_RETRIES   (2'd3)
    ) dut (
        .clk_in       (clk),
        .reset_n      (reset_n),
        .hpd          (hpd),
        .i2c          (bus),
        .video_reset  (video_reset),
        .config_done  (config_done),
        .config_error (config_error),
        .state_dbg    (state_dbg)
    );

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    int         rsp_countdown = 0;
    logic       pending_nack  = 1'b0;
    bit         no_respond    = 1'b0;
    logic [7:0] nack_reg      = 8'h00;
    int         nack_left     = 0;
    logic [7:0] hold_reg      = 8'h00;
    int         hold_left     = 0;
    int         last_rsp_cyc  = 0;

    logic [7:0] log_reg[$];
    logic [7:0] log_data[$];
    logic [6:0] log_dev[$];
    int         log_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    // I2C master model: accepts commands, answers 5 cycles after accept, optionally stalls or NACKs.
    always @(negedge clk) begin
        bus.rsp_valid = 1'b0;
        bus.rsp_nack  = 1'b0;
        if (rsp_countdown > 0) begin
            rsp_countdown--;
            if (rsp_countdown == 0) begin
                bus.rsp_valid = 1'b1;
                bus.rsp_nack  = pending_nack;
                last_rsp_cyc  = cyc;
            end
        end
        if (bus.cmd_valid && hold_left > 0 && bus.cmd_reg == hold_reg) begin
            bus.cmd_ready = 1'b0;
            hold_left--;
        end else begin
            bus.cmd_ready = 1'b1;
        end
        if (reset_n && bus.cmd_valid && bus.cmd_ready) begin
            log_reg.push_back(bus.cmd_reg);
            log_data.push_back(bus.cmd_data);
            log_dev.push_back(bus.cmd_dev);
            log_cyc.push_back(cyc);
            if (!no_respond) begin
                rsp_countdown = 5;
                pending_nack  = (nack_left > 0 && bus.cmd_reg == nack_reg);
                if (pending_nack) nack_left--;
            end
        end
    end

    task automatic clear_log();
        log_reg.delete();
        log_data.delete();
        log_dev.delete();
        log_cyc.delete();
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        hpd           = 1'b0;
        rsp_countdown = 0;
        no_respond    = 1'b0;
        nack_left     = 0;
        hold_left     = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        clear_log();
        @(negedge clk);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!config_done && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        hpd     = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.cmd_valid !== 1'b0) $display("[TB] FAIL reset_cmd_valid: got %b, expected 0", bus.cmd_valid); else passes++;
        checks++; if (bus.cmd_dev !== 7'h39) $display("[TB] FAIL reset_cmd_dev: got %h, expected 39", bus.cmd_dev); else passes++;
        checks++; if ({bus.cmd_reg, bus.cmd_data} !== 16'h0000) $display("[TB] FAIL reset_cmd_regdata: got %h%h, expected 0000", bus.cmd_reg, bus.cmd_data); else passes++;
        checks++; if (video_reset !== 1'b1) $display("[TB] FAIL reset_video_reset: got %b, expected 1", video_reset); else passes++;
        checks++; if ({config_done, config_error} !== 2'b00) $display("[TB] FAIL reset_flags: got %b, expected 00", {config_done, config_error}); else passes++;
        checks++; if (state_dbg !== 3'd0) $display("[TB] FAIL reset_state: got %0d, expected 0", state_dbg); else passes++;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_happy_path();
        int n;
        int done_cyc;
        int bad;
        do_reset();
        repeat (10) @(negedge clk);
        hpd = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (state_dbg !== 3'd0) $display("[TB] FAIL hpd_sync_depth: got %0d, expected 0", state_dbg); else passes++;
        @(negedge clk);
        checks++; if (state_dbg !== 3'd1) $display("[TB] FAIL power_wait_entry: got %0d, expected 1", state_dbg); else passes++;
        n = 0;
        while (state_dbg == 3'd1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n !== 16) $display("[TB] FAIL power_wait_len: got %0d, expected 16", n); else passes++;
        checks++; if ({state_dbg, bus.cmd_valid} !== {3'd2, 1'b1}) $display("[TB] FAIL first_issue: got state %0d valid %b, expected 2 1", state_dbg, bus.cmd_valid); else passes++;
        wait_done(2000);
        done_cyc = cyc;
        checks++; if (config_done !== 1'b1) $display("[TB] FAIL happy_done: got %b, expected 1", config_done); else passes++;
        checks++; if (done_cyc !== last_rsp_cyc + 1) $display("[TB] FAIL happy_done_latency: got %0d, expected %0d", done_cyc - last_rsp_cyc, 1); else passes++;
        checks++; if (video_reset !== 1'b0) $display("[TB] FAIL happy_video_reset: got %b, expected 0", video_reset); else passes++;
        checks++; if (log_reg.size() !== 13) $display("[TB] FAIL happy_cmd_count: got %0d, expected 13", log_reg.size()); else passes++;
        for (int i = 0; i < 13; i++) begin
            checks++;
            if (i >= log_reg.size()) $display("[TB] FAIL happy_entry_%0d: got none, expected %h", i, EXP[i]);
            else if ({log_reg[i], log_data[i]} !== EXP[i] || log_dev[i] !== 7'h39)
                $display("[TB] FAIL happy_entry_%0d: got dev %h %h, expected dev 39 %h", i, log_dev[i], {log_reg[i], log_data[i]}, EXP[i]);
            else passes++;
        end
        bad = 0;
        for (int i = 1; i < log_cyc.size(); i++) if (log_cyc[i] - log_cyc[i-1] != 6) bad++;
        checks++; if (bad !== 0) $display("[TB] FAIL happy_accept_spacing: got %0d bad gaps, expected 0", bad); else passes++;
    endtask

    task automatic test_unplug_done();
        hpd = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({video_reset, config_done} !== 2'b10) $display("[TB] FAIL unplug_done_flags: got %b, expected 10", {video_reset, config_done}); else passes++;
        checks++; if (state_dbg !== 3'd0) $display("[TB] FAIL unplug_done_state: got %0d, expected 0", state_dbg); else passes++;
    endtask

    task automatic test_replug();
        clear_log();
        hpd = 1'b1;
        wait_done(2000);
        checks++; if (config_done !== 1'b1) $display("[TB] FAIL replug_done: got %b, expected 1", config_done); else passes++;
        checks++;
        if (log_reg.size() != 13) $display("[TB] FAIL replug_cmd_count: got %0d, expected 13", log_reg.size());
        else if (log_reg[0] !== 8'h41 || log_reg[12] !== 8'hAF) $display("[TB] FAIL replug_order: got %h..%h, expected 41..AF", log_reg[0], log_reg[12]);
        else passes++;
    endtask

    task automatic test_nack_retry();
        int bad;
        do_reset();
        nack_reg  = 8'h9D;
        nack_left = 2;
        hpd       = 1'b1;
        wait_done(2000);
        checks++; if (config_done !== 1'b1) $display("[TB] FAIL nack_done: got %b, expected 1", config_done); else passes++;
        checks++;
        if (log_reg.size() != 15) begin
            $display("[TB] FAIL nack_cmd_count: got %0d, expected 15", log_reg.size());
        end else begin
            passes++;
            bad = 0;
            for (int i = 4; i <= 6; i++) if ({log_reg[i], log_data[i]} !== 16'h9D61) bad++;
            checks++; if (bad !== 0) $display("[TB] FAIL nack_repeat_entry: got %0d wrong, expected 0", bad); else passes++;
            checks++; if (log_reg[7] !== 8'hA2) $display("[TB] FAIL nack_advance: got %h, expected A2", log_reg[7]); else passes++;
            // Accept-to-accept after a NACK: 5 to response, 4 idle, 1 in ISSUE.
            checks++; if (log_cyc[5] - log_cyc[4] !== 10 || log_cyc[6] - log_cyc[5] !== 10)
                $display("[TB] FAIL nack_retry_gap: got %0d %0d, expected 10 10", log_cyc[5] - log_cyc[4], log_cyc[6] - log_cyc[5]); else passes++;
            checks++; if (log_cyc[7] - log_cyc[6] !== 6) $display("[TB] FAIL nack_after_ack_gap: got %0d, expected 6", log_cyc[7] - log_cyc[6]); else passes++;
        end
    endtask

    task automatic test_retry_exhaustion();
        int n;
        int bad;
        do_reset();
        no_respond = 1'b1;
        hpd        = 1'b1;
        n = 0;
        while (!config_error && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++; if (config_error !== 1'b1) $display("[TB] FAIL exhaust_error: got %b, expected 1", config_error); else passes++;
        checks++; if ({video_reset, config_done, state_dbg} !== {1'b1, 1'b0, 3'd6}) $display("[TB] FAIL exhaust_outputs: got %b%b %0d, expected 10 6", video_reset, config_done, state_dbg); else passes++;
        checks++;
        if (log_reg.size() != 4) begin
            $display("[TB] FAIL exhaust_attempts: got %0d, expected 4", log_reg.size());
        end else begin
            passes++;
            bad = 0;
            for (int i = 0; i < 4; i++) if ({log_reg[i], log_data[i]} !== 16'h4110) bad++;
            checks++; if (bad !== 0) $display("[TB] FAIL exhaust_entry: got %0d wrong, expected 0", bad); else passes++;
            // Timeout (32) + gap (4) + the ISSUE cycle before accept.
            bad = 0;
            for (int i = 1; i < 4; i++) if (log_cyc[i] - log_cyc[i-1] != 37) bad++;
            checks++; if (bad !== 0) $display("[TB] FAIL exhaust_spacing: got %0d bad gaps, expected 0", bad); else passes++;
            checks++; if (cyc - log_cyc[3] !== 33) $display("[TB] FAIL exhaust_error_latency: got %0d, expected 33", cyc - log_cyc[3]); else passes++;
        end
    endtask

    task automatic test_unplug_power_wait();
        int n;
        int bad;
        bit seen_valid;
        do_reset();
        hpd = 1'b1;
        n = 0;
        while (state_dbg != 3'd1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        repeat (8) @(negedge clk);
        hpd = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (state_dbg !== 3'd1) $display("[TB] FAIL pw_unplug_sync: got %0d, expected 1", state_dbg); else passes++;
        @(negedge clk);
        checks++; if (state_dbg !== 3'd0) $display("[TB] FAIL pw_unplug_state: got %0d, expected 0", state_dbg); else passes++;
        bad = 0;
        seen_valid = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (state_dbg != 3'd0) bad++;
            if (bus.cmd_valid) seen_valid = 1'b1;
        end
        checks++; if (bad !== 0 || seen_valid) $display("[TB] FAIL pw_unplug_idle: got %0d non-idle, valid %b, expected 0 0", bad, seen_valid); else passes++;
        checks++; if (log_reg.size() !== 0) $display("[TB] FAIL pw_unplug_no_cmd: got %0d, expected 0", log_reg.size()); else passes++;
    endtask

    task automatic test_back_pressure();
        int n;
        int bad_valid;
        int bad_reg;
        int bad_state;
        do_reset();
        hold_reg  = 8'hE0;
        hold_left = 20;
        hpd       = 1'b1;
        n = 0;
        while (!(bus.cmd_valid && bus.cmd_reg == 8'hE0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        bad_valid = 0;
        bad_reg   = 0;
        bad_state = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.cmd_valid !== 1'b1) bad_valid++;
            if ({bus.cmd_reg, bus.cmd_data} !== 16'hE0D0) bad_reg++;
            if (state_dbg !== 3'd2) bad_state++;
            @(negedge clk);
        end
        checks++; if (bad_valid !== 0) $display("[TB] FAIL bp_valid_held: got %0d drops, expected 0", bad_valid); else passes++;
        checks++; if (bad_reg !== 0) $display("[TB] FAIL bp_regdata_stable: got %0d changes, expected 0", bad_reg); else passes++;
        checks++; if (bad_state !== 0) $display("[TB] FAIL bp_stays_issue: got %0d other, expected 0", bad_state); else passes++;
        wait_done(2000);
        checks++;
        if (log_reg.size() != 13) $display("[TB] FAIL bp_cmd_count: got %0d, expected 13", log_reg.size());
        else if ({log_reg[7], log_data[7]} !== 16'hE0D0 || log_cyc[7] - log_cyc[6] != 26)
            $display("[TB] FAIL bp_accept: got %h after %0d, expected E0D0 after 26", {log_reg[7], log_data[7]}, log_cyc[7] - log_cyc[6]);
        else passes++;
    endtask

    task automatic test_async_reset();
        int n;
        do_reset();
        hpd = 1'b1;
        n = 0;
        while (!(state_dbg == 3'd3 && bus.cmd_reg == 8'hA3) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++; if (state_dbg !== 3'd3) $display("[TB] FAIL ar_reach_wait_rsp: got %0d, expected 3", state_dbg); else passes++;
        #2;
        reset_n = 1'b0;
        rsp_countdown = 0;
        #1;
        checks++;
        if ({bus.cmd_valid, bus.cmd_dev, bus.cmd_reg, bus.cmd_data, video_reset, config_done, config_error, state_dbg}
            !== {1'b0, 7'h39, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0})
            $display("[TB] FAIL ar_outputs: got v%b %h %h %h vr%b d%b e%b s%0d, expected v0 39 00 00 vr1 d0 e0 s0",
                     bus.cmd_valid, bus.cmd_dev, bus.cmd_reg, bus.cmd_data, video_reset, config_done, config_error, state_dbg);
        else passes++;
        @(negedge clk);
        clear_log();
        reset_n = 1'b1;
        wait_done(2000);
        checks++;
        if (log_reg.size() != 13) $display("[TB] FAIL ar_restart_count: got %0d, expected 13", log_reg.size());
        else if (log_reg[0] !== 8'h41) $display("[TB] FAIL ar_restart_first: got %h, expected 41", log_reg[0]);
        else passes++;
    endtask

    initial begin
        bus.cmd_ready = 1'b1;
        bus.rsp_valid = 1'b0;
        bus.rsp_nack  = 1'b0;
        test_reset();
        test_happy_path();
        test_unplug_done();
        test_replug();
        test_nack_retry();
        test_retry_exhaustion();
        test_unplug_power_wait();
        test_back_pressure();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
